// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode nibbles, NOOP encoding and default datapath widths.
package cpu_pkg;

   localparam int INST_BIT_WIDTH_DEF = 32;
   localparam int PC_WIDTH_DEF       = 32;

   typedef enum logic [3:0] {
      OP_ALU  = 4'b0000,
      OP_ALUI = 4'b1000,
      OP_CMP  = 4'b0010,
      OP_CMPI = 4'b1010,
      OP_BR   = 4'b0110,
      OP_LW   = 4'b1001,
      OP_SW   = 4'b0101,
      OP_JAL  = 4'b1011,
      OP_NOP  = 4'b1111
   } opcode_t;

   localparam logic [31:0] NOOP_INST = 32'hF000_0000;

endpackage

// File: rtl/fetch_skid_reg.sv
// One-entry holding register that catches the memory response landing during a decode stall.
module fetch_skid_reg #(
   parameter int DATA_W = 32,
   parameter int PC_W   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr,
   input  logic              rd,
   input  logic              flush,
   input  logic [DATA_W-1:0] wr_inst,
   input  logic [PC_W-1:0]   wr_pc,
   output logic              valid,
   output logic [DATA_W-1:0] inst,
   output logic [PC_W-1:0]   pc
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         valid <= 1'b0;
      else if (flush)
         valid <= 1'b0;
      else if (wr)
         valid <= 1'b1;
      else if (rd)
         valid <= 1'b0;
   end

   // Payload carries no reset; it is only observed while valid is set.
   always_ff @(posedge clk) begin
      if (wr && !flush) begin
         inst <= wr_inst;
         pc   <= wr_pc;
      end
   end

   a_no_overwrite : assert property (@(posedge clk) disable iff (!rst_n)
      !(wr && !flush && valid))
      else $error("fetch_skid_reg: write while entry occupied");

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, memory request, stall skid and the registered IF/ID slot.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter int                  INST_BIT_WIDTH = INST_BIT_WIDTH_DEF,
   parameter int                  PC_WIDTH       = PC_WIDTH_DEF,
   parameter logic [PC_WIDTH-1:0] START_PC       = PC_WIDTH'(32'h0000_0040)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      stall,
   input  logic                      redirect_valid,
   input  logic [PC_WIDTH-1:0]       redirect_pc,
   output logic                      imem_req,
   output logic [PC_WIDTH-1:0]       imem_addr,
   input  logic [INST_BIT_WIDTH-1:0] imem_rdata,
   output logic [INST_BIT_WIDTH-1:0] inst_out,
   output logic [PC_WIDTH-1:0]       pc_out,
   output logic [PC_WIDTH-1:0]       pc_next_out,
   output logic                      valid_out
);

   localparam logic [INST_BIT_WIDTH-1:0] NOOP = {OP_NOP, {(INST_BIT_WIDTH-4){1'b0}}};
   localparam logic [PC_WIDTH-1:0]       STEP = PC_WIDTH'(4);
   localparam logic [PC_WIDTH-1:0]       ALIGN_MASK = ~PC_WIDTH'(3);

   logic [PC_WIDTH-1:0]       pc;
   logic [PC_WIDTH-1:0]       target;
   logic                      rsp_pending;
   logic [PC_WIDTH-1:0]       rsp_pc;
   logic                      advance;
   logic                      skid_wr;
   logic                      skid_rd;
   logic                      skid_valid;
   logic [INST_BIT_WIDTH-1:0] skid_inst;
   logic [PC_WIDTH-1:0]       skid_pc;

   logic [INST_BIT_WIDTH-1:0] inst_d;
   logic [PC_WIDTH-1:0]       pc_d;
   logic [PC_WIDTH-1:0]       pc_next_d;
   logic                      valid_d;

   assign target    = redirect_pc & ALIGN_MASK;
   assign advance   = !redirect_valid && !stall;
   assign imem_req  = rst_n && (redirect_valid || !stall);
   assign imem_addr = redirect_valid ? target : pc;
   assign skid_wr   = stall && !redirect_valid && rsp_pending;
   assign skid_rd   = advance && skid_valid;

   // Request stage: PC and the registered request strobe that marks the response cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc          <= START_PC;
         rsp_pending <= 1'b0;
      end else begin
         rsp_pending <= imem_req;
         if (redirect_valid)
            pc <= target + STEP;
         else if (!stall)
            pc <= pc + STEP;
      end
   end

   always_ff @(posedge clk) begin
      rsp_pc <= imem_addr;
   end

   fetch_skid_reg #(
      .DATA_W (INST_BIT_WIDTH),
      .PC_W   (PC_WIDTH)
   ) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr      (skid_wr),
      .rd      (skid_rd),
      .flush   (redirect_valid),
      .wr_inst (imem_rdata),
      .wr_pc   (rsp_pc),
      .valid   (skid_valid),
      .inst    (skid_inst),
      .pc      (skid_pc)
   );

   // Response stage: choose what the IF/ID slot holds next cycle
   always_comb begin
      inst_d    = inst_out;
      pc_d      = pc_out;
      pc_next_d = pc_next_out;
      valid_d   = valid_out;
      if (redirect_valid) begin
         inst_d  = NOOP;
         valid_d = 1'b0;
      end else if (!stall) begin
         if (skid_valid) begin
            inst_d    = skid_inst;
            pc_d      = skid_pc;
            pc_next_d = skid_pc + STEP;
            valid_d   = 1'b1;
         end else if (rsp_pending) begin
            inst_d    = imem_rdata;
            pc_d      = rsp_pc;
            pc_next_d = rsp_pc + STEP;
            valid_d   = 1'b1;
         end else begin
            inst_d  = NOOP;
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inst_out    <= NOOP;
         pc_out      <= '0;
         pc_next_out <= '0;
         valid_out   <= 1'b0;
      end else begin
         inst_out    <= inst_d;
         pc_out      <= pc_d;
         pc_next_out <= pc_next_d;
         valid_out   <= valid_d;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, then model-checked stall/redirect traffic.
module tb_fetch_stage;

   localparam logic [31:0] NOOP = 32'hF000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = '0;
   logic [31:0] inst_out;
   logic [31:0] pc_out;
   logic [31:0] pc_next_out;
   logic        valid_out;

   int checks = 0;
   int errors = 0;

   fetch_stage dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .inst_out       (inst_out),
      .pc_out         (pc_out),
      .pc_next_out    (pc_next_out),
      .valid_out      (valid_out)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h5A00_0000 | {8'h00, a[23:0]};
   endfunction

   // Synchronous instruction memory: data one cycle after the strobe
   always @(posedge clk) begin
      if (imem_req) imem_rdata <= mem_word(imem_addr);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic        rst;
      logic        stl;
      logic        rdr;
      logic [31:0] rpc;
      logic        req;
      logic [31:0] addr;
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] pcn;
      logic        vld;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic r, input logic s, input logic d, input logic [31:0] rpc,
                      input logic q, input logic [31:0] a, input logic [31:0] i,
                      input logic [31:0] p, input logic [31:0] pn, input logic v);
      vec_t e;
      e = '{rst: r, stl: s, rdr: d, rpc: rpc, req: q, addr: a, inst: i, pc: p, pcn: pn, vld: v};
      vq.push_back(e);
   endtask

   // Reference model: FIFO of issued-but-undelivered fetch addresses
   logic [31:0] m_q[$];
   logic [31:0] m_pc;
   logic [31:0] m_inst, m_pco, m_pcn;
   logic        m_vld;

   task automatic model_reset();
      m_q.delete();
      m_pc   = 32'h40;
      m_inst = NOOP;
      m_pco  = 0;
      m_pcn  = 0;
      m_vld  = 0;
   endtask

   task automatic model_cycle(input logic s, input logic d, input logic [31:0] rpc);
      logic [31:0] tgt;
      logic [31:0] a;
      @(negedge clk);
      rst_n = 1'b1; stall = s; redirect_valid = d; redirect_pc = rpc;
      #1;
      tgt = rpc & ~32'h3;
      chk("rnd req", imem_req, d || !s);
      if (d) chk("rnd addr", imem_addr, tgt);
      else if (!s) chk("rnd addr", imem_addr, m_pc);
      chk("rnd inst", inst_out, m_inst);
      chk("rnd pc", pc_out, m_pco);
      chk("rnd pcn", pc_next_out, m_pcn);
      chk("rnd vld", valid_out, m_vld);
      if (d) begin
         m_q.delete();
         m_q.push_back(tgt);
         m_pc   = tgt + 4;
         m_inst = NOOP;
         m_vld  = 0;
      end else if (!s) begin
         if (m_q.size() > 0) begin
            a = m_q.pop_front();
            m_inst = mem_word(a);
            m_pco  = a;
            m_pcn  = a + 4;
            m_vld  = 1;
         end else begin
            m_inst = NOOP;
            m_vld  = 0;
         end
         m_q.push_back(m_pc);
         m_pc = m_pc + 4;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      // rst stl rdr rpc | req addr inst pc pcn vld
      add(1,0,0,0,           1,32'h40,       NOOP,               0,           0,           0);
      add(1,0,0,0,           1,32'h44,       NOOP,               0,           0,           0);
      add(1,0,0,0,           1,32'h48,       mem_word(32'h40),   32'h40,      32'h44,      1);
      add(1,0,0,0,           1,32'h4C,       mem_word(32'h44),   32'h44,      32'h48,      1);
      add(1,1,0,0,           0,0,            mem_word(32'h48),   32'h48,      32'h4C,      1);
      add(1,0,0,0,           1,32'h50,       mem_word(32'h48),   32'h48,      32'h4C,      1);
      add(1,0,0,0,           1,32'h54,       mem_word(32'h4C),   32'h4C,      32'h50,      1);
      add(1,0,0,0,           1,32'h58,       mem_word(32'h50),   32'h50,      32'h54,      1);
      add(1,0,1,32'h103,     1,32'h100,      mem_word(32'h54),   32'h54,      32'h58,      1);
      add(1,0,0,0,           1,32'h104,      NOOP,               32'h54,      32'h58,      0);
      add(1,0,0,0,           1,32'h108,      mem_word(32'h100),  32'h100,     32'h104,     1);
      add(1,1,0,0,           0,0,            mem_word(32'h104),  32'h104,     32'h108,     1);
      add(1,1,1,32'h200,     1,32'h200,      mem_word(32'h104),  32'h104,     32'h108,     1);
      add(1,0,0,0,           1,32'h204,      NOOP,               32'h104,     32'h108,     0);
      add(1,0,0,0,           1,32'h208,      mem_word(32'h200),  32'h200,     32'h204,     1);
      add(1,0,0,0,           1,32'h20C,      mem_word(32'h204),  32'h204,     32'h208,     1);
      add(1,0,1,32'hFFFFFFFC,1,32'hFFFFFFFC, mem_word(32'h208),  32'h208,     32'h20C,     1);
      add(1,0,0,0,           1,32'h0,        NOOP,               32'h208,     32'h20C,     0);
      add(1,0,0,0,           1,32'h4,        mem_word(32'hFFFFFFFC), 32'hFFFFFFFC, 32'h0,   1);
      add(1,0,0,0,           1,32'h8,        mem_word(32'h0),    32'h0,       32'h4,       1);
      add(1,1,0,0,           0,0,            mem_word(32'h4),    32'h4,       32'h8,       1);
      add(1,1,0,0,           0,0,            mem_word(32'h4),    32'h4,       32'h8,       1);
      add(0,1,0,0,           0,0,            NOOP,               0,           0,           0);
      add(0,0,0,0,           0,0,            NOOP,               0,           0,           0);
      add(1,0,0,0,           1,32'h40,       NOOP,               0,           0,           0);
      add(1,0,0,0,           1,32'h44,       NOOP,               0,           0,           0);
      add(1,0,0,0,           1,32'h48,       mem_word(32'h40),   32'h40,      32'h44,      1);

      repeat (3) @(negedge clk);
      #1;
      chk("reset req", imem_req, 1'b0);
      chk("reset inst", inst_out, NOOP);
      chk("reset vld", valid_out, 1'b0);

      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clk);
         rst_n = vq[i].rst; stall = vq[i].stl;
         redirect_valid = vq[i].rdr; redirect_pc = vq[i].rpc;
         #1;
         chk($sformatf("vec%0d req", i), imem_req, vq[i].req);
         if (vq[i].req) chk($sformatf("vec%0d addr", i), imem_addr, vq[i].addr);
         chk($sformatf("vec%0d inst", i), inst_out, vq[i].inst);
         chk($sformatf("vec%0d pc", i), pc_out, vq[i].pc);
         chk($sformatf("vec%0d pcn", i), pc_next_out, vq[i].pcn);
         chk($sformatf("vec%0d vld", i), valid_out, vq[i].vld);
      end

      // Fresh reset so the model and DUT start from the same state
      @(negedge clk);
      rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
      model_reset();
      #1;
      chk("rst2 inst", inst_out, NOOP);
      chk("rst2 pc", pc_out, 32'h0);

      // Multi-cycle stall, then stall straddling a redirect
      repeat (3) model_cycle(1'b0, 1'b0, 32'h0);
      repeat (4) model_cycle(1'b1, 1'b0, 32'h0);
      repeat (3) model_cycle(1'b0, 1'b0, 32'h0);
      model_cycle(1'b1, 1'b0, 32'h0);
      model_cycle(1'b1, 1'b1, 32'h0000_0302);
      repeat (3) model_cycle(1'b0, 1'b0, 32'h0);

      for (int n = 0; n < 500; n++) begin
         logic s, d;
         logic [31:0] rpc;
         s   = ($urandom_range(0, 9) < 3);
         d   = ($urandom_range(0, 9) == 0);
         rpc = $urandom;
         if ($urandom_range(0, 15) == 0) rpc = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
         model_cycle(s, d, rpc);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage sitting directly upstream of the decode controller. It owns the program counter, issues word reads to a synchronous instruction memory, and delivers `{inst, pc, pc+4}` through a registered IF/ID slot. The slot holds on decode stall and is flushed on branch/JAL redirect. Empty or squashed slots present the NOOP encoding (opcode `4'b1111`), so decode always sees a legal instruction.

## Interface
- `INST_BIT_WIDTH`, 32: instruction width.
- `PC_WIDTH`, 32: PC and memory byte-address width.
- `START_PC`, 32'h0000_0040: PC fetched first after reset.
- `clk`  in  1: sole clock, rising edge.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `stall`  in  1: decode cannot accept a new instruction this cycle.
- `redirect_valid`  in  1: taken branch or JAL resolved downstream.
- `redirect_pc`  in  PC_WIDTH: redirect target; bits [1:0] are ignored and forced to 0.
- `imem_req`  out  1: read strobe to instruction memory.
- `imem_addr`  out  PC_WIDTH: byte address, word-aligned.
- `imem_rdata`  in  INST_BIT_WIDTH: read data; valid exactly one cycle after `imem_req`.
- `inst_out`  out  INST_BIT_WIDTH: instruction to decode.
- `pc_out`  out  PC_WIDTH: address of `inst_out`.
- `pc_next_out`  out  PC_WIDTH: `pc_out + 4`, used as branch base and JAL link.
- `valid_out`  out  1: slot holds a real fetched instruction.

## Operation
Internal state:
- `pc`: next fetch address.
- `rsp_pending`: a response is arriving this cycle; this is the registered `imem_req`.
- `rsp_pc`: address of the pending response.
- 1-entry skid: `skid_valid`, `skid_inst`, `skid_pc`.
- IF/ID output registers.

Priority order each cycle: reset, then redirect, then stall, then normal.
- **Redirect** (overrides stall):
  - `imem_req=1`, `imem_addr=redirect_pc&~3`.
  - `pc <= target+4`.
  - Any response arriving this cycle is discarded.
  - Skid is cleared.
  - Output slot <= NOOP with `valid_out=0`.
- **Stall, no redirect**:
  - `imem_req=0`; `pc` holds; output registers hold.
  - If `rsp_pending`, the response and `rsp_pc` are written into the skid.
- **Normal**:
  - `imem_req=1`, `imem_addr=pc`, `pc <= pc+4`.
  - Output slot loads, in priority order: skid contents (then clear the skid); otherwise the pending response; otherwise NOOP with `valid_out=0`.
- Skid occupancy bound: no request is issued while stalled, so at most one response can target the skid. The skid can never overflow. A skid write while `skid_valid=1` is a design error; flag it with an assertion.
- NOOP encoding is `32'hF000_0000`. In a NOOP slot, `pc_out` and `pc_next_out` hold their previous values.
- PC arithmetic is modulo 2^PC_WIDTH: `pc+4` from `32'hFFFF_FFFC` wraps to 0.

## Timing
- Reset values (asynchronous):
  - `pc=START_PC`.
  - `rsp_pending=0`, `skid_valid=0`, `valid_out=0`.
  - `inst_out=32'hF000_0000`, `pc_out=0`, `pc_next_out=0`.
  - `imem_req=0` while `rst_n=0`.
- First cycle after reset release (C0): `imem_req=1`, `imem_addr=START_PC`.
- Fetch latency: request in cycle N, `imem_rdata` sampled in N+1, `inst_out` valid in N+2. Steady-state throughput is one instruction per cycle.
- Redirect in cycle R:
  - `valid_out=0` in R+1.
  - Target instruction presented in R+2.
  - No instruction fetched before R is ever presented after R.
- Stall asserted in cycles S..S+k, released in cycle U:
  - Outputs are unchanged through U.
  - The skid or pending instruction appears in U+1, with no gap and no duplicate.
- Reset asserted mid-operation: all state returns to reset values immediately, and the in-flight response is lost.

## Structure
- Shared package `cpu_pkg` holds:
  - `NOOP_INST=32'hF000_0000`.
  - Opcode-nibble constants (ALU `0000`, ALUI `1000`, CMP `0010`, CMPI `1010`, BR `0110`, LW `1001`, SW `0101`, JAL `1011`, NOP `1111`).
  - `INST_BIT_WIDTH` and `PC_WIDTH` defaults.
- One sub-module, `fetch_skid_reg`: the 1-entry holding register with write, read/clear and flush inputs, plus a valid flag.
- PC/request logic and the IF/ID register stay in `fetch_stage`.

## Test plan
- **Reset and straight-line fetch.** Reset with memory word@0x40=A, 0x44=B, 0x48=C; no stall. Required: `imem_addr` 0x40, 0x44, 0x48 in C0-C2; outputs A/0x40/0x44 in C2 and B/0x44/0x48 in C3, both `valid_out=1`; `inst_out=F000_0000` in C0-C1.
- **Single-cycle stall.** One-cycle stall during steady flow. Required: outputs frozen for exactly one extra cycle; the next instruction comes from the skid; no instruction is dropped or duplicated; `imem_req=0` during the stall.
- **Redirect.** `redirect_valid` with `redirect_pc=0x103` while two fetches are in flight. Required: `imem_addr=0x100` that cycle; `valid_out=0` next cycle; word@0x100 with `pc_next_out=0x104` the cycle after.
- **Redirect during stall.** Redirect and stall together, with the skid full. Required: skid flushed, NOOP output, target presented two cycles later.
- **PC wraparound.** Redirect to 0xFFFF_FFFC. Required: next fetch address is 0x0; `pc_next_out=0x0` for that slot.
- **Reset mid-operation.** Assert `rst_n=0` mid-stall with the skid full. Required: all outputs take reset values immediately; after release, fetching restarts at 0x40.
